i2c_slave_byte_ctl: RTL and testbench

- I2C target (slave) byte engine. It is the responder counterpart to the master byte controller.
- Filters SCL/SDA and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then shifts data bytes in (master write) or out (master read).
- Sits beside the master in the i2c top level, sharing the SCL/SDA iobuf pins. Register glue feeds it I2CADR[7:1] and I2CDFSRR[5:0].

---
 rtl/i2c_slave_byte_ctl_pkg.sv | 19 +
 rtl/i2c_slave_byte_ctl_line_filter.sv | 50 +++++
 rtl/i2c_slave_byte_ctl.sv | 192 +++++++++++++++++++
 tb/tb_i2c_slave_byte_ctl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_byte_ctl_pkg.sv
// Shared definitions for the I2C target byte engine: slave state encodings
// and the width of the line-filter stability counter.
package i2c_slave_byte_ctl_pkg;

  typedef enum logic [2:0] {
    SS_IDLE     = 3'd0,
    SS_ADDR     = 3'd1,
    SS_ADDR_ACK = 3'd2,
    SS_RX       = 3'd3,
    SS_RX_ACK   = 3'd4,
    SS_TX       = 3'd5,
    SS_TX_ACK   = 3'd6,
    SS_WAIT     = 3'd7
  } slave_state_e;

  // Wide enough to hold the largest I2CDFSRR value (63).
  localparam int FILT_CNT_W = 6;

endpackage

// File: rtl/i2c_slave_byte_ctl_line_filter.sv
// i2c_line_filter: synchronizer, stable-count glitch filter and edge pulses for
// one I2C line. Filtered copy changes only after i_dfsr+1 consecutive equal samples.
module i2c_line_filter
  import i2c_slave_byte_ctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_sysclk,
  input  logic                  i_reset,
  input  logic                  i_line,
  input  logic [FILT_CNT_W-1:0] i_dfsr,
  output logic                  o_line,
  output logic                  o_rise,
  output logic                  o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_CNT_W-1:0]  cnt_q;
  logic                   filt_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: every flop here updates with <= so each one samples the pre-edge value of the others.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
      prev_q <= filt_q;
      if (synced == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == i_dfsr) begin
        filt_q <= synced;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_line = filt_q;
  assign o_rise = filt_q & ~prev_q;
  assign o_fall = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_slave_byte_ctl.sv
// I2C target byte engine: START/STOP detection, 7-bit address match, byte RX/TX.
// Optional SCL clock stretching on TX underrun: define I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_byte_ctl
  import i2c_slave_byte_ctl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_sysclk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [6:0] i_slave_addr,
  input  logic [5:0] i_dfsr,
  input  logic       i_ack_en,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_addressed,
  output logic       o_srw,
  output logic       o_rxak,
  output logic       o_busy,
  output logic       o_stop,
  output logic       o_tx_underrun,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda,
  output logic       o_sda_oen,
  output logic       o_scl_oen
);

  slave_state_e state_q;
  logic [7:0]   shift_q, rx_data_q, load_byte;
  logic [3:0]   bit_cnt_q;
  logic         sda_oen_q, addressed_q, srw_q, rxak_q, busy_q;
  logic         stop_q, tx_req_q, rx_valid_q, underrun_q;
  logic         scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;
  logic         start_det, stop_det, load_ev, do_load;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl_filt (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_line(i_scl), .i_dfsr(i_dfsr),
    .o_line(scl_f), .o_rise(scl_rise), .o_fall(scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda_filt (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_line(i_sda), .i_dfsr(i_dfsr),
    .o_line(sda_f), .o_rise(sda_rise), .o_fall(sda_fall)
  );

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  // A byte is due after our address ACK on a read, or after the master ACKs a byte.
  assign load_ev   = scl_fall & (((state_q == SS_ADDR_ACK) & srw_q) |
                                 ((state_q == SS_TX_ACK) & ~rxak_q));

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic stretch_q, scl_oen_q;

  always_ff @(posedge i_sysclk) begin
    if (i_reset || !i_enable || start_det || stop_det) begin
      stretch_q <= 1'b0;
      scl_oen_q <= 1'b1;
    end else if (load_ev && !i_tx_valid) begin
      stretch_q <= 1'b1;
      scl_oen_q <= 1'b0;
    end else if (stretch_q && i_tx_valid) begin
      stretch_q <= 1'b0;
    end else if (!stretch_q) begin
      scl_oen_q <= 1'b1;
    end
  end

  assign do_load   = i_tx_valid & (load_ev | stretch_q);
  assign load_byte = i_tx_data;
  assign o_scl_oen = scl_oen_q;
`else
  assign do_load   = load_ev;
  assign load_byte = i_tx_valid ? i_tx_data : 8'hFF;
  assign o_scl_oen = 1'b1;
`endif

  always_ff @(posedge i_sysclk) begin
    tx_req_q   <= 1'b0;
    rx_valid_q <= 1'b0;
    stop_q     <= 1'b0;
    if (i_reset || !i_enable) begin
      state_q     <= SS_IDLE;
      shift_q     <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      sda_oen_q   <= 1'b1;
      addressed_q <= 1'b0;
      srw_q       <= 1'b0;
      rxak_q      <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else if (stop_det) begin
      state_q     <= SS_IDLE;
      sda_oen_q   <= 1'b1;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      stop_q      <= addressed_q;
    end else if (start_det) begin
      state_q     <= SS_ADDR;
      sda_oen_q   <= 1'b1;
      addressed_q <= 1'b0;
      bit_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      if (scl_rise) begin
        if (state_q == SS_ADDR || state_q == SS_RX) begin
          shift_q   <= {shift_q[6:0], sda_f};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (state_q == SS_TX) begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (state_q == SS_TX_ACK) begin
          rxak_q <= sda_f;
        end
      end

      if (scl_fall) begin
        case (state_q)
          SS_ADDR: if (bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == i_slave_addr) begin
              state_q     <= SS_ADDR_ACK;
              sda_oen_q   <= 1'b0;
              addressed_q <= 1'b1;
              srw_q       <= shift_q[0];
            end else begin
              state_q <= SS_IDLE;
            end
          end
          SS_ADDR_ACK: begin
            sda_oen_q <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= srw_q ? SS_TX : SS_RX;
          end
          SS_RX: if (bit_cnt_q == 4'd8) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
            sda_oen_q  <= ~i_ack_en;
            state_q    <= SS_RX_ACK;
          end
          SS_RX_ACK: begin
            sda_oen_q <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= SS_RX;
          end
          SS_TX: if (bit_cnt_q == 4'd8) begin
            sda_oen_q <= 1'b1;
            state_q   <= SS_TX_ACK;
          end else begin
            shift_q   <= {shift_q[6:0], 1'b0};
            sda_oen_q <= shift_q[6];
          end
          SS_TX_ACK: begin
            bit_cnt_q <= '0;
            if (rxak_q) begin
              sda_oen_q <= 1'b1;
              state_q   <= SS_WAIT;
            end else begin
              state_q <= SS_TX;
            end
          end
          default: ;
        endcase
      end

      // Placed after the fall handling so the MSB drive overrides the ACK release.
      if (do_load) begin
        shift_q   <= load_byte;
        sda_oen_q <= load_byte[7];
        tx_req_q  <= 1'b1;
        if (!i_tx_valid) underrun_q <= 1'b1;
      end
    end
  end

  assign o_tx_req      = tx_req_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_addressed   = addressed_q;
  assign o_srw         = srw_q;
  assign o_rxak        = rxak_q;
  assign o_busy        = busy_q;
  assign o_stop        = stop_q;
  assign o_tx_underrun = underrun_q;
  assign o_sda         = 1'b0;
  assign o_sda_oen     = sda_oen_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctl.sv
// Directed bench for i2c_slave_byte_ctl: a bit-banged I2C master on a wired-AND
// bus with expected values worked out by hand for each transaction.
module tb_i2c_slave_byte_ctl;

  localparam int H = 20;

  logic       i_sysclk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_enable = 1'b0;
  logic [6:0] i_slave_addr = 7'h50;
  logic [5:0] i_dfsr = 6'd1;
  logic       i_ack_en = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       i_scl, i_sda;
  logic       o_tx_req, o_rx_valid, o_addressed, o_srw, o_rxak, o_busy, o_stop;
  logic       o_tx_underrun, o_sda, o_sda_oen, o_scl_oen;
  logic [7:0] o_rx_data;

  assign i_scl = m_scl & o_scl_oen;
  assign i_sda = m_sda & (o_sda_oen ? 1'b1 : o_sda);

  i2c_slave_byte_ctl #(.SYNC_STAGES(2)) dut (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_enable(i_enable),
    .i_slave_addr(i_slave_addr), .i_dfsr(i_dfsr), .i_ack_en(i_ack_en),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_req(o_tx_req),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_addressed(o_addressed),
    .o_srw(o_srw), .o_rxak(o_rxak), .o_busy(o_busy), .o_stop(o_stop),
    .o_tx_underrun(o_tx_underrun), .i_scl(i_scl), .i_sda(i_sda), .o_sda(o_sda),
    .o_sda_oen(o_sda_oen), .o_scl_oen(o_scl_oen)
  );

  always #5 i_sysclk = ~i_sysclk;

  int n_checks = 0;
  int n_errors = 0;
  int rx_cnt = 0, txreq_cnt = 0, stop_cnt = 0, sda_drv_cnt = 0;
  logic [7:0] rx_log [0:15];

  always @(negedge i_sysclk) begin
    if (o_rx_valid) begin
      rx_log[rx_cnt[3:0]] = o_rx_data;
      rx_cnt++;
    end
    if (o_tx_req) txreq_cnt++;
    if (o_stop) stop_cnt++;
    if (!o_sda_oen) sda_drv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge i_sysclk);
  endtask

  task automatic scl_up();
    m_scl = 1'b1;
    for (int i = 0; i < 400 && i_scl !== 1'b1; i++) @(posedge i_sysclk);
    if (i_scl !== 1'b1) check("scl_release_timeout", {31'd0, i_scl}, 32'd1);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;
    clks(H);
    scl_up();
    clks(H);
    m_scl = 1'b0;
    clks(4);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1;
    clks(H);
    scl_up();
    clks(H / 2);
    @(negedge i_sysclk);
    b = i_sda;
    clks(H / 2);
    m_scl = 1'b0;
    clks(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic bb;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bb);
      d[i] = bb;
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    clks(H);
    scl_up();
    clks(H);
    m_sda = 1'b0;
    clks(H);
    m_scl = 1'b0;
    clks(4);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    clks(H);
    scl_up();
    clks(H);
    m_sda = 1'b1;
    clks(H);
  endtask

  task automatic scl_glitch();
    m_sda = 1'b1;
    clks(H);
    m_scl = 1'b1;
    clks(3);
    m_scl = 1'b0;
    clks(H);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d, d2;
    int         b0, s0, t0, v0;

    // Reset state
    clks(5);
    @(negedge i_sysclk);
    check("rst_sda_oen", {31'd0, o_sda_oen}, 32'd1);
    check("rst_scl_oen", {31'd0, o_scl_oen}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_addressed", {31'd0, o_addressed}, 32'd0);
    check("rst_rx_data", {24'd0, o_rx_data}, 32'd0);
    check("rst_underrun", {31'd0, o_tx_underrun}, 32'd0);
    check("rst_sda", {31'd0, o_sda}, 32'd0);
    i_reset = 1'b0;
    i_enable = 1'b1;
    clks(10);

    // Master write 0xA0, 0x3C, 0xC3
    b0 = rx_cnt; s0 = stop_cnt;
    start_cond();
    @(negedge i_sysclk);
    check("t1_busy_start", {31'd0, o_busy}, 32'd1);
    write_byte(8'hA0, ack);
    check("t1_addr_ack", {31'd0, ack}, 32'd0);
    check("t1_addressed", {31'd0, o_addressed}, 32'd1);
    check("t1_srw", {31'd0, o_srw}, 32'd0);
    write_byte(8'h3C, ack);
    check("t1_ack1", {31'd0, ack}, 32'd0);
    write_byte(8'hC3, ack);
    check("t1_ack2", {31'd0, ack}, 32'd0);
    stop_cond();
    @(negedge i_sysclk);
    check("t1_rx_count", rx_cnt - b0, 32'd2);
    check("t1_rx0", {24'd0, rx_log[b0]}, 32'h3C);
    check("t1_rx1", {24'd0, rx_log[b0+1]}, 32'hC3);
    check("t1_stop_count", stop_cnt - s0, 32'd1);
    check("t1_busy_end", {31'd0, o_busy}, 32'd0);
    check("t1_addressed_end", {31'd0, o_addressed}, 32'd0);

    // Wrong address 0xA2
    b0 = rx_cnt; s0 = stop_cnt; v0 = sda_drv_cnt;
    start_cond();
    write_byte(8'hA2, ack);
    check("t2_nack", {31'd0, ack}, 32'd1);
    @(negedge i_sysclk);
    check("t2_addressed", {31'd0, o_addressed}, 32'd0);
    check("t2_busy", {31'd0, o_busy}, 32'd1);
    stop_cond();
    @(negedge i_sysclk);
    check("t2_sda_driven", sda_drv_cnt - v0, 32'd0);
    check("t2_rx_count", rx_cnt - b0, 32'd0);
    check("t2_stop_count", stop_cnt - s0, 32'd0);
    check("t2_busy_end", {31'd0, o_busy}, 32'd0);

    // Master read 0x5A then 0x96, NACK on the second byte
    i_tx_data = 8'h5A; i_tx_valid = 1'b1;
    t0 = txreq_cnt; s0 = stop_cnt;
    start_cond();
    write_byte(8'hA1, ack);
    check("t3_addr_ack", {31'd0, ack}, 32'd0);
    check("t3_srw", {31'd0, o_srw}, 32'd1);
    read_byte(d);
    i_tx_data = 8'h96;
    write_bit(1'b0);
    read_byte(d2);
    write_bit(1'b1);
    @(negedge i_sysclk);
    check("t3_byte0", {24'd0, d}, 32'h5A);
    check("t3_byte1", {24'd0, d2}, 32'h96);
    check("t3_tx_req_count", txreq_cnt - t0, 32'd2);
    check("t3_rxak", {31'd0, o_rxak}, 32'd1);
    check("t3_sda_released", {31'd0, o_sda_oen}, 32'd1);
    check("t3_underrun", {31'd0, o_tx_underrun}, 32'd0);
    stop_cond();
    @(negedge i_sysclk);
    check("t3_stop_count", stop_cnt - s0, 32'd1);

    // SCL glitch of 3 clocks: filtered with dfsr=4, counted with dfsr=1
    i_dfsr = 6'd4;
    clks(10);
    start_cond();
    scl_glitch();
    write_byte(8'hA0, ack);
    check("t4_dfsr4_ack", {31'd0, ack}, 32'd0);
    check("t4_dfsr4_addressed", {31'd0, o_addressed}, 32'd1);
    stop_cond();
    i_dfsr = 6'd1;
    clks(10);
    start_cond();
    scl_glitch();
    write_byte(8'hA0, ack);
    check("t4_dfsr1_ack", {31'd0, ack}, 32'd1);
    check("t4_dfsr1_addressed", {31'd0, o_addressed}, 32'd0);
    stop_cond();

    // Repeated START after a write byte, then a read address
    i_tx_data = 8'h5A; i_tx_valid = 1'b1;
    b0 = rx_cnt;
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h11, ack);
    check("t5_rx_count_pre", rx_cnt - b0, 32'd1);
    check("t5_rx_data", {24'd0, rx_log[b0]}, 32'h11);
    start_cond();
    @(negedge i_sysclk);
    check("t5_addressed_cleared", {31'd0, o_addressed}, 32'd0);
    check("t5_busy", {31'd0, o_busy}, 32'd1);
    write_byte(8'hA1, ack);
    check("t5_addr_ack", {31'd0, ack}, 32'd0);
    check("t5_srw", {31'd0, o_srw}, 32'd1);
    read_byte(d);
    check("t5_byte", {24'd0, d}, 32'h5A);
    write_bit(1'b1);
    stop_cond();
    check("t5_rx_count_post", rx_cnt - b0, 32'd1);

    // Master read with no transmit data available
    i_tx_valid = 1'b0;
    t0 = txreq_cnt;
    start_cond();
    write_byte(8'hA1, ack);
    check("t6_addr_ack", {31'd0, ack}, 32'd0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    fork
      read_byte(d);
      begin
        for (int i = 0; i < 100 && o_scl_oen !== 1'b0; i++) @(posedge i_sysclk);
        check("t6_stretch_start", {31'd0, o_scl_oen}, 32'd0);
        clks(20);
        @(negedge i_sysclk);
        check("t6_stretch_hold", {31'd0, i_scl}, 32'd0);
        @(posedge i_sysclk);
        i_tx_data = 8'h5A;
        i_tx_valid = 1'b1;
      end
    join
    check("t6_byte", {24'd0, d}, 32'h5A);
    check("t6_underrun", {31'd0, o_tx_underrun}, 32'd0);
`else
    read_byte(d);
    check("t6_byte", {24'd0, d}, 32'hFF);
    check("t6_underrun", {31'd0, o_tx_underrun}, 32'd1);
`endif
    check("t6_tx_req_count", txreq_cnt - t0, 32'd1);
    write_bit(1'b1);
    stop_cond();
    @(negedge i_sysclk);
`ifndef I2C_SLAVE_CLK_STRETCH_EN
    check("t6_underrun_sticky", {31'd0, o_tx_underrun}, 32'd1);
`endif
    start_cond();
    @(negedge i_sysclk);
    check("t6_underrun_cleared", {31'd0, o_tx_underrun}, 32'd0);
    write_byte(8'hA2, ack);
    stop_cond();
    clks(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
